// File: rtl/pkg_rv32_types.sv
// Shared RV32 SoC types: DMA engine state encoding and transfer direction constants.
package pkg_rv32_types;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    GAP,
    DRAIN,
    DONE
  } dma_state_e;

  localparam logic DMA_DIR_RD = 1'b0;
  localparam logic DMA_DIR_WR = 1'b1;

endpackage

// File: rtl/dma_sync_fifo.sv
// Synchronous show-ahead FIFO; rdata is the current head whenever empty is low.
module dma_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/accel_dma_engine.sv
// Descriptor-less DMA between unified SRAM and the accelerator stream, with burst cap,
// forced idle gap and a one-cycle completion interrupt.
module accel_dma_engine
  import pkg_rv32_types::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_MAX  = 16,
  parameter int GAP_CYCLES = 2,
  parameter int MEM_BYTES  = 65536
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_dir,
  input  logic [XLEN-1:0] cfg_base_addr,
  input  logic [15:0]     cfg_len,
  output logic            cfg_busy,
  output logic            cfg_err,
  output logic            dma_req,
  output logic            dma_we,
  output logic [XLEN-1:0] dma_addr,
  output logic [XLEN-1:0] dma_wdata,
  input  logic [XLEN-1:0] dma_rdata,
  input  logic            dma_grant,
  output logic            m_valid,
  output logic            m_last,
  output logic [XLEN-1:0] m_data,
  input  logic            m_ready,
  input  logic            s_valid,
  input  logic [XLEN-1:0] s_data,
  output logic            s_ready,
  output logic            done_irq
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(BURST_MAX + 1);
  localparam int GW  = $clog2(GAP_CYCLES + 1);

  dma_state_e      state_q, state_d;
  logic            dir_q;
  logic            err_q;
  logic [XLEN-1:0] addr_q;
  logic [15:0]     len_q;
  logic [16:0]     xfer_cnt_q;
  logic [16:0]     acc_cnt_q;
  logic [16:0]     pop_cnt_q;
  logic [BW-1:0]   burst_q;
  logic [GW-1:0]   gap_q;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FAW:0]    fifo_count;
  logic [XLEN-1:0] fifo_wdata, fifo_head;

  logic            is_rd, cfg_bad, start_seen;
  logic [XLEN+1:0] end_addr;
  logic [16:0]     len_ext;
  logic            xfer, last_xfer, burst_hit, all_issued;
  logic            m_pop, s_push;

  assign is_rd   = (dir_q == DMA_DIR_RD);
  assign len_ext = {1'b0, len_q};

  // Bounds check is done wide enough that base + 4*len can never wrap.
  assign end_addr   = {2'b00, cfg_base_addr} + {{(XLEN-16){1'b0}}, cfg_len, 2'b00};
  assign cfg_bad    = (cfg_len == '0) || (cfg_base_addr[1:0] != 2'b00) ||
                      (end_addr > (XLEN+2)'(MEM_BYTES));
  assign start_seen = (state_q == IDLE) && cfg_start;

  // Requests and stream handshakes are decoded from registered state only.
  assign dma_req = (state_q == RUN) &&
                   (is_rd ? ((xfer_cnt_q < len_ext) && (fifo_count != (FAW+1)'(FIFO_DEPTH)))
                          : !fifo_empty);
  assign dma_we  = dma_req && (dir_q == DMA_DIR_WR);
  assign dma_addr  = addr_q;
  assign dma_wdata = (dir_q == DMA_DIR_WR && !fifo_empty) ? fifo_head : '0;

  assign m_valid = is_rd && !fifo_empty;
  assign m_data  = m_valid ? fifo_head : '0;
  assign m_last  = m_valid && (pop_cnt_q == len_ext - 17'd1);
  assign s_ready = !is_rd && (state_q == RUN || state_q == GAP) && !fifo_full &&
                   (acc_cnt_q < len_ext);

  assign xfer       = dma_req && dma_grant;
  assign last_xfer  = xfer && (xfer_cnt_q == len_ext - 17'd1);
  assign burst_hit  = xfer && (burst_q == BW'(BURST_MAX - 1));
  assign all_issued = (xfer_cnt_q == len_ext);
  assign m_pop      = m_valid && m_ready;
  assign s_push     = s_valid && s_ready;

  assign fifo_push  = is_rd ? xfer : s_push;
  assign fifo_pop   = is_rd ? m_pop : xfer;
  assign fifo_wdata = is_rd ? dma_rdata : s_data;

  assign cfg_busy = (state_q != IDLE);
  assign cfg_err  = err_q;
  assign done_irq = (state_q == DONE);

  dma_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: the default assignment first means every path assigns state_d, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_seen && !cfg_bad) state_d = RUN;
      RUN: begin
        if (burst_hit)      state_d = GAP;
        else if (last_xfer) state_d = is_rd ? DRAIN : DONE;
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (all_issued) state_d = is_rd ? DRAIN : DONE;
          else            state_d = RUN;
        end
      end
      DRAIN: if (fifo_empty) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= DMA_DIR_RD;
      err_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      xfer_cnt_q <= '0;
      acc_cnt_q  <= '0;
      pop_cnt_q  <= '0;
      burst_q    <= '0;
      gap_q      <= '0;
    end else begin
      state_q <= state_d;

      if (start_seen) begin
        if (cfg_bad) begin
          err_q <= 1'b1;
        end else begin
          err_q      <= 1'b0;
          dir_q      <= cfg_dir;
          addr_q     <= cfg_base_addr;
          len_q      <= cfg_len;
          xfer_cnt_q <= '0;
          acc_cnt_q  <= '0;
          pop_cnt_q  <= '0;
          burst_q    <= '0;
        end
      end

      if (xfer) begin
        addr_q     <= addr_q + XLEN'(4);
        xfer_cnt_q <= xfer_cnt_q + 17'd1;
      end

      // Burst length counts back-to-back grants; any idle RUN cycle restarts it.
      if (state_q == RUN) begin
        if (burst_hit)  burst_q <= '0;
        else if (xfer)  burst_q <= burst_q + 1'b1;
        else            burst_q <= '0;
      end

      gap_q <= (state_q == GAP) ? gap_q + 1'b1 : '0;

      if (m_pop)  pop_cnt_q <= pop_cnt_q + 17'd1;
      if (s_push) acc_cnt_q <= acc_cnt_q + 17'd1;
    end
  end

endmodule

// File: tb/tb_accel_dma_engine.sv
// Directed self-checking bench for accel_dma_engine with a behavioural SRAM model.
module tb_accel_dma_engine;
  import pkg_rv32_types::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_dir = 1'b0;
  logic [31:0] cfg_base_addr = '0;
  logic [15:0] cfg_len = '0;
  logic        cfg_busy, cfg_err;
  logic        dma_req, dma_we, dma_grant;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        m_valid, m_last, m_ready = 1'b0;
  logic [31:0] m_data;
  logic        s_valid = 1'b0, s_ready;
  logic [31:0] s_data;
  logic        done_irq;
  logic        grant_en = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  // SRAM model and activity logs, written only by the negedge monitor.
  logic [31:0] sram [16384];
  bit          sram_init = 1'b0;
  logic [31:0] acc_addr [$];
  logic [31:0] acc_data [$];
  bit          acc_we [$];
  int          acc_cyc [$];
  logic [31:0] rd_data [$];
  bit          rd_last [$];
  int          irq_cnt = 0;
  int          stab_viol = 0;
  int          cyc = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  bit          prev_we;

  logic [31:0] s_cnt = '0;
  logic [31:0] s_base = '0;

  assign dma_grant = grant_en;
  assign dma_rdata = sram[dma_addr[15:2]];
  assign s_data    = s_cnt - s_base;

  accel_dma_engine #(
    .XLEN(32), .FIFO_DEPTH(4), .BURST_MAX(16), .GAP_CYCLES(2), .MEM_BYTES(65536)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_dir(cfg_dir), .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_grant(dma_grant),
    .m_valid(m_valid), .m_last(m_last), .m_data(m_data), .m_ready(m_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int w);
    return 32'(w - 'h40 + 'hA);
  endfunction

  always @(posedge clk) begin
    if (s_valid && s_ready) s_cnt <= s_cnt + 32'd1;
  end

  always @(negedge clk) begin
    cyc++;
    if (!sram_init) begin
      for (int i = 0; i < 16384; i++) sram[i] = init_word(i);
      sram_init = 1'b1;
    end
    if (prev_stall && (dma_addr !== prev_addr || dma_wdata !== prev_wdata || dma_we !== prev_we))
      stab_viol++;
    prev_stall = dma_req && !dma_grant;
    prev_addr  = dma_addr;
    prev_wdata = dma_wdata;
    prev_we    = dma_we;
    if (dma_req && dma_grant) begin
      acc_addr.push_back(dma_addr);
      acc_data.push_back(dma_wdata);
      acc_we.push_back(dma_we);
      acc_cyc.push_back(cyc);
      if (dma_we) sram[dma_addr[15:2]] = dma_wdata;
    end
    if (m_valid && m_ready) begin
      rd_data.push_back(m_data);
      rd_last.push_back(m_last);
    end
    if (done_irq) irq_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic dir, input logic [31:0] base, input logic [15:0] len);
    cfg_dir       = dir;
    cfg_base_addr = base;
    cfg_len       = len;
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (cfg_busy && k < 1000) begin
      tick();
      k++;
    end
    check({name, "_idle"}, 32'(cfg_busy), 32'd0);
  endtask

  task automatic check_outs_zero(input string name);
    check({name, "_ctl"}, 32'({cfg_busy, cfg_err, dma_req, dma_we, m_valid, m_last, s_ready, done_irq}), 32'd0);
    check({name, "_addr"}, dma_addr, 32'd0);
    check({name, "_wdata"}, dma_wdata, 32'd0);
    check({name, "_mdata"}, m_data, 32'd0);
  endtask

  typedef struct {
    logic        dir;
    logic [31:0] base;
    logic [15:0] len;
    logic        exp_err;
  } cfg_vec_t;

  cfg_vec_t vecs [6];
  int a0, r0, i0, v0;

  initial begin
    vecs[0] = '{DMA_DIR_RD, 32'h0000_0100, 16'd0, 1'b1};
    vecs[1] = '{DMA_DIR_RD, 32'h0000_0102, 16'd1, 1'b1};
    vecs[2] = '{DMA_DIR_RD, 32'h0000_FFFC, 16'd2, 1'b1};
    vecs[3] = '{DMA_DIR_RD, 32'h0000_FFFC, 16'd1, 1'b0};
    vecs[4] = '{DMA_DIR_WR, 32'h0001_0000, 16'd1, 1'b1};
    vecs[5] = '{DMA_DIR_WR, 32'h0000_0500, 16'd2, 1'b0};

    // Reset state
    repeat (3) tick();
    check_outs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Configuration acceptance / rejection table
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a0 = acc_addr.size();
      i0 = irq_cnt;
      do_start(vecs[i].dir, vecs[i].base, vecs[i].len);
      check($sformatf("cfg%0d_err", i), 32'(cfg_err), 32'(vecs[i].exp_err));
      check($sformatf("cfg%0d_busy", i), 32'(cfg_busy), 32'(!vecs[i].exp_err));
      wait_idle($sformatf("cfg%0d", i));
      check($sformatf("cfg%0d_irqs", i), 32'(irq_cnt - i0), vecs[i].exp_err ? 32'd0 : 32'd1);
      check($sformatf("cfg%0d_accs", i), 32'(acc_addr.size() - a0),
            vecs[i].exp_err ? 32'd0 : 32'(vecs[i].len));
    end
    s_valid = 1'b0;
    tick();

    // Read 3 words from 0x100: first request latency and first data latency
    a0 = acc_addr.size(); r0 = rd_data.size(); i0 = irq_cnt;
    do_start(DMA_DIR_RD, 32'h100, 16'd3);
    check("rd3_first_req", 32'({cfg_busy, dma_req, dma_we}), 32'b110);
    check("rd3_first_addr", dma_addr, 32'h100);
    tick();
    check("rd3_first_mvalid", 32'(m_valid), 32'd1);
    check("rd3_first_mdata", m_data, 32'hA);
    wait_idle("rd3");
    check("rd3_nwords", 32'(rd_data.size() - r0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rd3_data%0d", i), rd_data[r0+i], 32'hA + 32'(i));
      check($sformatf("rd3_last%0d", i), 32'(rd_last[r0+i]), (i == 2) ? 32'd1 : 32'd0);
      check($sformatf("rd3_addr%0d", i), acc_addr[a0+i], 32'h100 + 32'(4*i));
    end
    check("rd3_irqs", 32'(irq_cnt - i0), 32'd1);

    // Write 20 words to 0x200: 16-grant burst, 2-cycle gap, 4 more grants
    a0 = acc_addr.size(); i0 = irq_cnt;
    s_base  = s_cnt;
    s_valid = 1'b1;
    do_start(DMA_DIR_WR, 32'h200, 16'd20);
    wait_idle("wr20");
    s_valid = 1'b0;
    check("wr20_accs", 32'(acc_addr.size() - a0), 32'd20);
    check("wr20_burst_span", 32'(acc_cyc[a0+15] - acc_cyc[a0]), 32'd15);
    check("wr20_gap", 32'(acc_cyc[a0+16] - acc_cyc[a0+15]), 32'd3);
    check("wr20_tail_span", 32'(acc_cyc[a0+19] - acc_cyc[a0+16]), 32'd3);
    for (int i = 0; i < 20; i++)
      check($sformatf("wr20_sram%0d", i), sram[('h200 >> 2) + i], 32'(i));
    check("wr20_irqs", 32'(irq_cnt - i0), 32'd1);

    // Read 8 words with the stream stalled for 10 cycles
    a0 = acc_addr.size(); r0 = rd_data.size(); i0 = irq_cnt;
    m_ready = 1'b0;
    do_start(DMA_DIR_RD, 32'h300, 16'd8);
    repeat (10) tick();
    check("rd8_stall_accs", 32'(acc_addr.size() - a0), 32'd4);
    check("rd8_stall_req", 32'(dma_req), 32'd0);
    m_ready = 1'b1;
    wait_idle("rd8");
    check("rd8_accs", 32'(acc_addr.size() - a0), 32'd8);
    check("rd8_nwords", 32'(rd_data.size() - r0), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("rd8_data%0d", i), rd_data[r0+i], init_word(('h300 >> 2) + i));
    check("rd8_irqs", 32'(irq_cnt - i0), 32'd1);

    // Write with grant withheld 3 cycles; a second start mid-run is ignored
    a0 = acc_addr.size(); i0 = irq_cnt; v0 = stab_viol;
    grant_en = 1'b0;
    s_base   = s_cnt;
    s_valid  = 1'b1;
    do_start(DMA_DIR_WR, 32'h400, 16'd4);
    tick();
    check("wrstall_req", 32'({dma_req, dma_we}), 32'b11);
    do_start(DMA_DIR_RD, 32'h0, 16'd1);
    tick();
    tick();
    check("wrstall_hold_addr", dma_addr, 32'h400);
    check("wrstall_hold_wdata", dma_wdata, 32'd0);
    grant_en = 1'b1;
    wait_idle("wrstall");
    s_valid = 1'b0;
    repeat (5) tick();
    check("wrstall_stable", 32'(stab_viol - v0), 32'd0);
    check("wrstall_accs", 32'(acc_addr.size() - a0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrstall_addr%0d", i), acc_addr[a0+i], 32'h400 + 32'(4*i));
      check($sformatf("wrstall_sram%0d", i), sram[('h400 >> 2) + i], 32'(i));
    end
    check("wrstall_irqs", 32'(irq_cnt - i0), 32'd1);

    // Reset in the middle of a stalled read, then restart from word 0
    i0 = irq_cnt;
    m_ready = 1'b0;
    do_start(DMA_DIR_RD, 32'h300, 16'd8);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check_outs_zero("midrst");
    rst_n = 1'b1;
    repeat (3) tick();
    check("midrst_irqs", 32'(irq_cnt - i0), 32'd0);
    r0 = rd_data.size();
    m_ready = 1'b1;
    do_start(DMA_DIR_RD, 32'h300, 16'd2);
    wait_idle("postrst");
    check("postrst_nwords", 32'(rd_data.size() - r0), 32'd2);
    check("postrst_data0", rd_data[r0], init_word('h300 >> 2));
    check("postrst_data1", rd_data[r0+1], init_word(('h300 >> 2) + 1));
    check("postrst_last", 32'({rd_last[r0], rd_last[r0+1]}), 32'b01);
    check("postrst_irqs", 32'(irq_cnt - i0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
